// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: shared state enum, default widths and the clamped duty-step helper for the PWM fade controller
package pwm_ctrl_pkg;
   localparam int DUTY_W_DEF = 8;
   localparam int IVL_W_DEF = 16;
   typedef enum logic {ST_IDLE, ST_RAMP} state_t;
   // Widths are fixed at 32 so any DUTY_W up to 31 fits; the extra diff bit keeps the distance exact.
   function automatic logic [31:0] next_duty(input logic [31:0] duty, input logic [31:0] target, input logic [31:0] step);
      logic [32:0] diff;
      diff = target > duty ? 33'(target) - 33'(duty) : 33'(duty) - 33'(target);
      return diff <= 33'(step) ? target : target > duty ? duty + step : duty - step;
   endfunction
endpackage

// File: rtl/fade_tick_timer.sv
// fade_tick_timer: loadable down-counter that ticks at zero when not held
// ports: clk, rst, load/load_val (restart count), hold (freeze), reload_val (value after a tick), tick (step strobe)
module fade_tick_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         hold,
   input  logic [W-1:0] reload_val,
   output logic         tick
);
   logic [W-1:0] count;
   assign tick = count == '0 && !hold;
   always_ff @(posedge clk) begin
      if (rst) count <= '0;
      else if (load) count <= load_val;
      else if (!hold) count <= count == '0 ? reload_val : count - W'(1);
   end
endmodule

// File: rtl/pwm_fade_controller.sv
// pwm_fade_controller: ramps the live PWM duty toward a programmed target by step_eff every ivl_eff clocks
// ports: clk, rst, cfg_valid/cfg_target/cfg_step/cfg_interval (load), pause (freeze ramp),
//        duty_out (live duty), busy (ramping), done (one-cycle completion / no-op load pulse)
module pwm_fade_controller
   import pwm_ctrl_pkg::*;
#(
   parameter int DUTY_W = DUTY_W_DEF,
   parameter int IVL_W = IVL_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   input  logic [DUTY_W-1:0] cfg_target,
   input  logic [DUTY_W-1:0] cfg_step,
   input  logic [IVL_W-1:0]  cfg_interval,
   input  logic              pause,
   output logic [DUTY_W-1:0] duty_out,
   output logic              busy,
   output logic              done
);
   state_t state, state_n;
   logic [DUTY_W-1:0] target, target_n, step_eff, step_n, duty_n;
   logic [IVL_W-1:0] ivl_eff, ivl_n;
   logic done_n, tick;
   fade_tick_timer #(.W(IVL_W)) u_timer (
      .clk(clk),
      .rst(rst),
      .load(cfg_valid),
      .load_val(ivl_n - IVL_W'(1)),
      .hold(pause || state == ST_IDLE),
      .reload_val(ivl_eff - IVL_W'(1)),
      .tick(tick)
   );
   assign busy = state == ST_RAMP;
   always_comb begin
      state_n = state;
      target_n = target;
      step_n = step_eff;
      ivl_n = ivl_eff;
      duty_n = duty_out;
      done_n = 1'b0;
      if (cfg_valid) begin
         target_n = cfg_target;
         step_n = cfg_step == '0 ? DUTY_W'(1) : cfg_step;
         ivl_n = cfg_interval == '0 ? IVL_W'(1) : cfg_interval;
         done_n = cfg_target == duty_out;
         state_n = done_n ? ST_IDLE : ST_RAMP;
      end else if (state == ST_RAMP && tick) begin
         duty_n = DUTY_W'(next_duty(32'(duty_out), 32'(target), 32'(step_eff)));
         done_n = duty_n == target;
         state_n = done_n ? ST_IDLE : ST_RAMP;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         target <= '0;
         step_eff <= DUTY_W'(1);
         ivl_eff <= IVL_W'(1);
         duty_out <= '0;
         done <= 1'b0;
      end else begin
         state <= state_n;
         target <= target_n;
         step_eff <= step_n;
         ivl_eff <= ivl_n;
         duty_out <= duty_n;
         done <= done_n;
      end
   end
endmodule
